// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the round engine.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } aes_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for a round number; out-of-range numbers give zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] rc);
        if (rc == 4'd0 || rc > 4'd10) return 8'h00;
        return RCON[rc];
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 0 sits in the top bits; bytes run column-major through the state.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        return r;
    endfunction

    // Row r of the state rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, key XOR,
// plus the on-the-fly key schedule step that produces the next round key.
module aes_roundkey
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [3:0]   rc,
    output logic [127:0] key_out
);
    logic [31:0] w0, w1, w2, w3, rot, temp;

    // One key-expansion step: RotWord, SubWord and Rcon on the last word,
    // then a running XOR across the four words.
    always_comb begin
        w0   = key_in[127:96];
        w1   = key_in[95:64];
        w2   = key_in[63:32];
        w3   = key_in[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
               ^ {rcon_of(rc), 24'h000000};
        key_out[127:96] = w0 ^ temp;
        key_out[95:64]  = w1 ^ w0 ^ temp;
        key_out[63:32]  = w2 ^ w1 ^ w0 ^ temp;
        key_out[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;
    end
endmodule

module aes_round_datapath
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state_in,
    input  logic [AES_BLOCK_W-1:0] key_in,
    input  logic [AES_BLOCK_W-1:0] mix_in,
    input  logic [3:0]             rc,
    input  logic                   mix_en,
    output logic [AES_BLOCK_W-1:0] sr_out,
    output logic [AES_BLOCK_W-1:0] next_key,
    output logic [AES_BLOCK_W-1:0] round_out
);
    aes_roundkey u_roundkey (
        .key_in  (key_in),
        .rc      (rc),
        .key_out (next_key)
    );

    // The second half takes mix_in so the engine can register the
    // SubBytes/ShiftRows result between the two halves when rounds are split.
    always_comb begin
        sr_out    = shift_rows(sub_bytes(state_in));
        round_out = (mix_en ? mix_columns(mix_in) : mix_in) ^ next_key;
    end
endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption core with valid/ready handshakes on both sides.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS   = 10,
    parameter int ROUND_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic [AES_BLOCK_W-1:0] in_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy,
    output logic [3:0]             round_idx
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    aes_state_e state, next_state;
    logic phase, last_phase, handshake;
    logic [AES_BLOCK_W-1:0] state_reg, key_reg, sr_out, mix_in, next_key, round_out;

    assign last_phase = (ROUND_CYCLES == 1) || phase;
    assign handshake  = (state == DONE) && out_valid && out_ready;

    aes_round_datapath u_datapath (
        .state_in  (state_reg),
        .key_in    (key_reg),
        .mix_in    (mix_in),
        .rc        (round_idx),
        .mix_en    (state == ROUND),
        .sr_out    (sr_out),
        .next_key  (next_key),
        .round_out (round_out)
    );

    generate
        if (ROUND_CYCLES == 2) begin : g_split
            logic [AES_BLOCK_W-1:0] sr_reg;
            // Holds the SubBytes/ShiftRows result between the two halves of a round.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr_reg <= '0;
                else if ((state == ROUND || state == FINAL) && !phase) sr_reg <= sr_out;
            end
            assign mix_in = sr_reg;
        end else begin : g_single
            assign mix_in = sr_out;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; rounds advance only on the last phase of a round.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = (NUM_ROUNDS > 1) ? ROUND : FINAL;
            ROUND:   if (last_phase && (round_idx + 4'd1) == LAST_IDX) next_state = FINAL;
            FINAL:   if (last_phase) next_state = DONE;
            DONE:    if (handshake) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers and registered status outputs; out_valid rises one
    // cycle into DONE so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            round_idx <= 4'd0;
            state_reg <= '0;
            key_reg   <= '0;
            phase     <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            busy      <= (next_state == ROUND) || (next_state == FINAL);
            out_valid <= (state == DONE) && !handshake;
            phase     <= (ROUND_CYCLES == 2) && (state == ROUND || state == FINAL) && !phase;
            case (state)
                IDLE: if (in_valid) begin
                    state_reg <= in_data ^ in_key;
                    key_reg   <= in_key;
                    round_idx <= 4'd1;
                end
                ROUND: if (last_phase) begin
                    state_reg <= round_out;
                    key_reg   <= next_key;
                    round_idx <= round_idx + 4'd1;
                end
                FINAL: if (last_phase) out_data <= round_out;
                DONE:  if (handshake) round_idx <= 4'd0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed-vector bench: three engines (10x1, 10x2 and 1x1 round configs)
// on one clock and reset, checked against FIPS-197 values.
module tb_aes_round_engine;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    // Round-1 ShiftRows output d4bf5d30e0b452aeb84111f11e2798e5 XOR round key a0fafe1788542cb123a339392a6c7605
    localparam logic [127:0] CT_B_R1 = 128'h7445a32768e07e1f9be228c8344beee0;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] in_valid, out_ready;
    logic [127:0] in_data [3];
    logic [127:0] in_key [3];
    logic ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [127:0] od0, od1, od2;
    logic [3:0] ri0, ri1, ri2;
    logic [2:0] in_ready, out_valid, busy;

    int checks = 0;
    int fails = 0;

    assign in_ready  = {ir2, ir1, ir0};
    assign out_valid = {ov2, ov1, ov0};
    assign busy      = {bz2, bz1, bz0};

    always #5 clk = ~clk;

    aes_round_engine #(.NUM_ROUNDS(10), .ROUND_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir0),
        .in_data(in_data[0]), .in_key(in_key[0]), .out_valid(ov0), .out_ready(out_ready[0]),
        .out_data(od0), .busy(bz0), .round_idx(ri0));

    aes_round_engine #(.NUM_ROUNDS(10), .ROUND_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir1),
        .in_data(in_data[1]), .in_key(in_key[1]), .out_valid(ov1), .out_ready(out_ready[1]),
        .out_data(od1), .busy(bz1), .round_idx(ri1));

    aes_round_engine #(.NUM_ROUNDS(1), .ROUND_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir2),
        .in_data(in_data[2]), .in_key(in_key[2]), .out_valid(ov2), .out_ready(out_ready[2]),
        .out_data(od2), .busy(bz2), .round_idx(ri2));

    function automatic logic [127:0] odata(input int u);
        case (u)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Push one block into engine u, measure latency, optionally poke in_valid
    // mid-run and hold off out_ready, then complete the output handshake.
    task automatic applyStimulus(input int u, input string tag, input logic [127:0] key,
                                 input logic [127:0] pt, input logic [127:0] exp_ct,
                                 input int exp_lat, input int hold, input int poke);
        int n;
        int lat;
        int unstable;
        logic [127:0] res;
        n = 0;
        while (in_ready[u] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        in_key[u]   = key;
        in_data[u]  = pt;
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        checkOutput({tag, "_busy"}, 128'(busy[u]), 128'd1);
        checkOutput({tag, "_ready_low"}, 128'(in_ready[u]), 128'd0);
        lat = 0;
        while (out_valid[u] !== 1'b1 && lat < 100) begin
            if (poke > 0 && lat == poke) begin
                checkOutput({tag, "_poke_ready"}, 128'(in_ready[u]), 128'd0);
                in_key[u]   = KEY_C1;
                in_data[u]  = PT_C1;
                in_valid[u] = 1'b1;
            end
            @(posedge clk); #1;
            in_valid[u] = 1'b0;
            lat++;
        end
        checkOutput({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        res = odata(u);
        checkOutput({tag, "_data"}, res, exp_ct);
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (odata(u) !== res || in_ready[u] !== 1'b0 || out_valid[u] !== 1'b1) unstable++;
        end
        if (hold > 0) checkOutput({tag, "_hold_unstable_cycles"}, 128'(unstable), 128'd0);
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        checkOutput({tag, "_ready_back"}, 128'(in_ready[u]), 128'd1);
        checkOutput({tag, "_valid_drop"}, 128'(out_valid[u]), 128'd0);
    endtask

    initial begin
        int n;
        int stray;
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_data[i] = '0;
            in_key[i]  = '0;
        end
        #12;
        checkOutput("reset_in_ready", 128'(ir0), 128'd1);
        checkOutput("reset_out_valid", 128'(ov0), 128'd0);
        checkOutput("reset_out_data", od0, 128'd0);
        checkOutput("reset_busy", 128'(bz0), 128'd0);
        checkOutput("reset_round_idx", 128'(ri0), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, "c1", KEY_C1, PT_C1, CT_C1, 11, 20, 0);
        applyStimulus(0, "busy_ignore", KEY_B, PT_B, CT_B, 11, 0, 3);
        applyStimulus(1, "b_rc2", KEY_B, PT_B, CT_B, 21, 2, 0);
        applyStimulus(2, "b_r1", KEY_B, PT_B, CT_B_R1, 2, 2, 0);

        $display("[TB] reset during round 5");
        @(negedge clk);
        in_key[0]   = KEY_C1;
        in_data[0]  = PT_C1;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (ri0 !== 4'd5 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("reach_round5", 128'(ri0), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 128'(ir0), 128'd1);
        checkOutput("abort_out_valid", 128'(ov0), 128'd0);
        checkOutput("abort_busy", 128'(bz0), 128'd0);
        checkOutput("abort_round_idx", 128'(ri0), 128'd0);
        checkOutput("abort_out_data", od0, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (ov0 !== 1'b0) stray++;
        end
        checkOutput("abort_no_output", 128'(stray), 128'd0);
        applyStimulus(0, "c1_after_reset", KEY_C1, PT_C1, CT_C1, 11, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
